// File: rtl/sram_dma.sv
// Block-copy / fill engine driving one port of the dual-port SRAM.
// Optional fill mode is built only when SRAM_DMA_FILL_EN is defined.
module sram_dma #(
    parameter int AW = 16,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          fill_mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    input  logic [31:0]   fill_data,
    output logic          busy,
    output logic          done,
    output logic          ram_en,
    output logic          ram_we,
    output logic [3:0]    ram_wem,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout
);

    typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] src_ptr, dst_ptr;
    logic [LW-1:0] count;
    logic          accept;
    logic          last;

    assign accept = (state == IDLE) && start && !abort;
    assign last   = (count == LW'(1));

`ifdef SRAM_DMA_FILL_EN
    logic [31:0] fill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fill_q <= '0;
        else if (accept)
            fill_q <= fill_data;
    end
`else
    logic unused_fill;
    assign unused_fill = ^{fill_mode, fill_data};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Pointers and count; the abort cycle's access still advances them, harmlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
        end else if (accept) begin
            src_ptr <= src_addr;
            dst_ptr <= dst_addr;
            count   <= len;
        end else if (state == WR) begin
            src_ptr <= src_ptr + 1'b1;
            dst_ptr <= dst_ptr + 1'b1;
            count   <= count - 1'b1;
        end else if (state == FILL) begin
            dst_ptr <= dst_ptr + 1'b1;
            count   <= count - 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (len == '0)
                        state_nx = DONE;
`ifdef SRAM_DMA_FILL_EN
                    else if (fill_mode)
                        state_nx = FILL;
`endif
                    else
                        state_nx = RD;
                end
            end
            RD:      state_nx = abort ? IDLE : WR;
            WR:      state_nx = abort ? IDLE : (last ? DONE : RD);
`ifdef SRAM_DMA_FILL_EN
            FILL:    state_nx = abort ? IDLE : (last ? DONE : FILL);
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_wem  = '0;
        ram_addr = '0;
        ram_din  = '0;
        case (state)
            RD: begin
                busy     = 1'b1;
                ram_en   = 1'b1;
                ram_addr = src_ptr;
            end
            WR: begin
                busy     = 1'b1;
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_wem  = '1;
                ram_addr = dst_ptr;
                ram_din  = ram_dout;
            end
`ifdef SRAM_DMA_FILL_EN
            FILL: begin
                busy     = 1'b1;
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_wem  = '1;
                ram_addr = dst_ptr;
                ram_din  = fill_q;
            end
`endif
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_dma.sv
// Scoreboard bench for sram_dma: expected RAM accesses and done pulses are
// queued per command and matched by a negedge monitor against a 1-cycle SRAM model.
module tb_sram_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        fill_mode = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic [31:0] fill_data = '0;
    logic        busy, done, ram_en, ram_we;
    logic [3:0]  ram_wem;
    logic [15:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = '0;

    sram_dma #(.AW(16), .LW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .fill_mode(fill_mode), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .fill_data(fill_data), .busy(busy), .done(done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_wem(ram_wem),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:65535];

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int unsigned b = 0; b < 4; b++)
                    if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [15:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t rq[$];
    acc_t wq[$];
    int   dq[$];
    int   busy_lo = 1, busy_hi = 0;
    int   n_checks = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            acc_t e;
            chk("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
            if (ram_en && ram_we) begin
                if (wq.size() == 0) chk("unexpected_write", 64'(ram_addr), 64'hFFFF_FFFF);
                else begin
                    e = wq.pop_front();
                    chk("wr_cycle", 64'(cyc), 64'(e.c));
                    chk("wr_addr", 64'(ram_addr), 64'(e.addr));
                    chk("wr_data", 64'(ram_din), 64'(e.data));
                    chk("wr_mask", 64'(ram_wem), 64'hF);
                end
            end else if (ram_en) begin
                if (rq.size() == 0) chk("unexpected_read", 64'(ram_addr), 64'hFFFF_FFFF);
                else begin
                    e = rq.pop_front();
                    chk("rd_cycle", 64'(cyc), 64'(e.c));
                    chk("rd_addr", 64'(ram_addr), 64'(e.addr));
                end
            end
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
                else chk("done_cycle", 64'(cyc), 64'(dq.pop_front()));
            end
        end
    end

    // Drives a command; returns cyc value seen during cycle 1.
    task automatic issue(input logic fm, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] n, input logic [31:0] fd, output int a);
        @(negedge clk);
        fill_mode = fm; src_addr = s; dst_addr = d; len = n; fill_data = fd; start = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        start = 1'b0;
    endtask

    // Expected copy of n words whose source k holds base+k.
    task automatic expect_copy(input int a, input logic [15:0] s, input logic [15:0] d,
                               input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            rq.push_back('{a + 2*k, 16'(s + 16'(k)), 32'h0});
            wq.push_back('{a + 2*k + 1, 16'(d + 16'(k)), base + 32'(k)});
        end
        dq.push_back(a + 2*n);
        busy_lo = a; busy_hi = a + 2*n - 1;
    endtask

    task automatic drain(input string name);
        int left = 200;
        while (left > 0 && (rq.size() + wq.size() + dq.size()) != 0) begin
            @(posedge clk);
            left--;
        end
        chk(name, 64'(rq.size() + wq.size() + dq.size()), 64'h0);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int a;
        for (int unsigned i = 0; i < 4; i++) mem[16'h0100 + 16'(i)] = 32'hA0 + i;
        mem[16'hFFFE] = 32'h5000_0000;
        mem[16'hFFFF] = 32'h5000_0001;
        mem[16'h0000] = 32'h5000_0002;
        for (int unsigned i = 0; i < 10; i++) mem[16'h0500 + 16'(i)] = 32'h6000 + i;
        for (int unsigned i = 0; i < 8; i++)  mem[16'h0700 + 16'(i)] = 32'h7000 + i;

        #1;
        chk("reset_outputs", 64'({busy, done, ram_en, ram_we, ram_wem, ram_addr, ram_din}), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 4-word copy: writes in cycles 2,4,6,8, done in 9
        issue(1'b0, 16'h0100, 16'h0200, 16'd4, 32'h0, a);
        expect_copy(a, 16'h0100, 16'h0200, 4, 32'hA0);
        drain("copy4_drain");
        for (int unsigned i = 0; i < 4; i++)
            chk("copy4_mem", 64'(mem[16'h0200 + 16'(i)]), 64'(32'hA0 + i));

        // Zero length: done in cycle 1, no access, no busy
        issue(1'b0, 16'h0100, 16'h0300, 16'd0, 32'h0, a);
        dq.push_back(a);
        drain("zero_len_drain");

        // Wrap-around of the source pointer
        issue(1'b0, 16'hFFFE, 16'h0010, 16'd3, 32'h0, a);
        expect_copy(a, 16'hFFFE, 16'h0010, 3, 32'h5000_0000);
        drain("wrap_drain");

        // Abort during the third RD (cycle 5)
        issue(1'b0, 16'h0500, 16'h0600, 16'd10, 32'h0, a);
        rq.push_back('{a,     16'h0500, 32'h0});
        wq.push_back('{a + 1, 16'h0600, 32'h6000});
        rq.push_back('{a + 2, 16'h0501, 32'h0});
        wq.push_back('{a + 3, 16'h0601, 32'h6001});
        rq.push_back('{a + 4, 16'h0502, 32'h0});
        busy_lo = a; busy_hi = a + 4;
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        drain("abort_drain");
        chk("abort_no_third_write", 64'(mem[16'h0602] === 32'h6002), 64'h0);

        // Fill, or copy from src when fill is not built
        issue(1'b1, 16'h0100, 16'h0040, 16'd3, 32'hDEAD_BEEF, a);
`ifdef SRAM_DMA_FILL_EN
        for (int k = 0; k < 3; k++) wq.push_back('{a + k, 16'h0040 + 16'(k), 32'hDEAD_BEEF});
        dq.push_back(a + 3);
        busy_lo = a; busy_hi = a + 2;
`else
        expect_copy(a, 16'h0100, 16'h0040, 3, 32'hA0);
`endif
        drain("fill_drain");

        // Reset mid-copy: outputs clear immediately
        issue(1'b0, 16'h0700, 16'h0800, 16'd8, 32'h0, a);
        expect_copy(a, 16'h0700, 16'h0800, 8, 32'h7000);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_mid_outputs", 64'({busy, done, ram_en, ram_we, ram_wem, ram_addr, ram_din}), 64'h0);
        rq.delete(); wq.delete(); dq.delete();
        busy_lo = 1; busy_hi = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Start while busy is ignored
        issue(1'b0, 16'h0100, 16'h0900, 16'd3, 32'h0, a);
        expect_copy(a, 16'h0100, 16'h0900, 3, 32'hA0);
        @(posedge clk);
        #1;
        src_addr = 16'h0000; dst_addr = 16'h0A00; len = 16'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        drain("busy_start_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d expected 0 pending", rq.size() + wq.size() + dq.size());
        $fatal(1);
    end

endmodule
